cpu_sram_arbiter: RTL and testbench
===================================

# cpu_sram_arbiter

Two-requester arbiter that shares one sram-like memory port between the CPU instruction-fetch port and data-access port. It sits between the pipeline top (IF stage inst port, EXE/MEM data port) and a single unified memory or bus bridge. Each requester gets at most one transaction outstanding at a time. Data has fixed priority over instruction fetch, with a bounded-starvation override for fetch.

## Interface
- STARVE_MAX, 4: max consecutive tie losses for inst before it wins the next tie; 0 = strict data priority
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req / data_req  in  1  request valid; requester holds all request fields stable until its addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  00 byte, 01 half, 10 word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted (1-cycle pulse)
- inst_data_ok / data_data_ok  out  1  response (1-cycle pulse)
- inst_rdata / data_rdata  out  32  read data, valid only with own data_ok
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_addr, mem_wdata  out  1/2/32/32  fields of granted requester
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data

## Operation
- FSM states: IDLE, REQ, WAIT; grant register gnt (0 = inst, 1 = data).
- IDLE: if any req, pick the winner, latch it into gnt, go to REQ. Otherwise stay in IDLE.
- Pick rule:
  - only one requester asserts req: it wins;
  - both assert and starve_cnt == STARVE_MAX with STARVE_MAX != 0: inst wins;
  - both assert otherwise: data wins.
- starve_cnt:
  - increments on each pick where both requested and data won; saturates at STARVE_MAX;
  - clears on any inst grant.
- REQ: mem_req = 1. mem_wr, mem_size, mem_addr and mem_wdata are combinationally muxed from the gnt requester. The granted addr_ok = mem_addr_ok in the same cycle. On mem_addr_ok, go to WAIT.
- WAIT: on mem_data_ok, the granted data_ok = 1 for that cycle.
  - If any req is asserted that cycle, re-pick, update gnt and go directly to REQ.
  - Otherwise go to IDLE.
- inst_rdata = data_rdata = mem_rdata (broadcast); consumers qualify with their own data_ok.
- Outside REQ, mem_req = 0 and mem_wr, mem_size, mem_addr, mem_wdata = 0.
- Both addr_ok outputs are 0 outside REQ; both data_ok outputs are 0 outside WAIT.
- The non-granted requester never sees addr_ok or data_ok.

## Timing
- Reset (async, resetn low): state = IDLE, gnt = 0, starve_cnt = 0. All outputs = 0 except the rdata buses, which follow mem_rdata.
- Reset mid-transaction drops the transaction; no data_ok is issued afterwards. Downstream is reset by the same resetn.
- Request to mem_req: 1 cycle (IDLE→REQ registered). addr_ok is combinational from mem_addr_ok. data_ok is combinational from mem_data_ok.
- Back-to-back throughput: a new REQ starts the cycle after data_ok, so the minimum is 2 cycles per transaction with zero-wait memory.
- mem_data_ok in IDLE or REQ is a protocol violation; it is ignored and causes no state change.
- mem_addr_ok outside REQ is ignored.
- A requester dropping req while granted in REQ is a protocol violation; the arbiter stays in REQ with mem_req = 1.
- A req that arrives in the same cycle as data_ok in WAIT is arbitrated that cycle; there is no IDLE bubble.

## Structure
- Shared package holds:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2);
  - grant encoding (GNT_INST = 1'b0, GNT_DATA = 1'b1);
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module sram_grant_pick holds the pick logic plus the starve_cnt register. Inputs: clk, resetn, inst_req, data_req, pick_en. Output: pick_gnt.
- The top holds the FSM, the gnt register and the field/response muxes.

## Test plan
- Single inst read, addr 0xBFC00000, memory addr_ok after 0 cycles and data_ok after 2 cycles, rdata 0x24010001 → inst_addr_ok in cycle 1, inst_data_ok with rdata 0x24010001 in cycle 3; data_* outputs stay 0.
- inst_req and data_req (write, addr 0x1000, wdata 0xDEADBEEF, size 10) asserted together → data granted first (mem_wr = 1, mem_addr = 0x1000). inst is granted in the REQ that directly follows data's data_ok.
- STARVE_MAX = 4, both requesting continuously → grant sequence D, D, D, D, I, D, D, D, D, I. STARVE_MAX = 0 → inst never granted while data_req stays high.
- mem_addr_ok held low for 5 cycles in REQ → mem_req and mem fields stable for 5 cycles; no addr_ok pulse until mem_addr_ok rises.
- resetn pulsed low during WAIT → all outputs are 0 immediately; after release, a stale mem_data_ok is ignored and the next req is serviced normally.
- Spurious mem_data_ok in IDLE → no data_ok on either port; state stays IDLE.

Source files
------------

// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the CPU inst/data SRAM-port arbiter.
package cpu_sram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/sram_grant_pick.sv
// Winner selection between inst and data requests: data first, with a bounded
// starvation override that hands a tie to inst after STARVE_MAX lost ties.
module sram_grant_pick
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  input  logic pick_en,
  output logic pick_gnt
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             both_req;
  logic             starved;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    both_req = inst_req & data_req;
    starved  = (STARVE_MAX != 0) && (starve_cnt == CNT_MAX);
    pick_gnt = GNT_DATA;
    if (inst_req && !data_req) begin
      pick_gnt = GNT_INST;
    end else if (both_req && starved) begin
      pick_gnt = GNT_INST;
    end
  end

  // With STARVE_MAX = 0 the counter is pinned at zero and never reaches "starved".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (pick_en) begin
      if (pick_gnt == GNT_INST) begin
        starve_cnt <= '0;
      end else if (both_req) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like memory port between the CPU inst-fetch and data ports,
// one transaction in flight at a time.
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       gnt, gnt_nxt;
  logic       any_req;
  logic       pick_en;
  logic       pick_gnt;

  sram_grant_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .resetn   (resetn),
    .inst_req (inst_req),
    .data_req (data_req),
    .pick_en  (pick_en),
    .pick_gnt (pick_gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      gnt   <= GNT_INST;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_comb begin
    any_req      = inst_req | data_req;
    state_nxt    = state;
    gnt_nxt      = gnt;
    pick_en      = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          pick_en   = 1'b1;
          gnt_nxt   = pick_gnt;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (gnt == GNT_DATA) begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end else begin
          mem_wr       = inst_wr;
          mem_size     = inst_size;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          inst_addr_ok = mem_addr_ok;
        end
        if (mem_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Re-arbitrate in the response cycle so back-to-back requests skip IDLE.
        if (mem_data_ok) begin
          inst_data_ok = (gnt == GNT_INST);
          data_data_ok = (gnt == GNT_DATA);
          if (any_req) begin
            pick_en   = 1'b1;
            gnt_nxt   = pick_gnt;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the arbitration rules.
module tb_cpu_sram_arbiter;
  import cpu_sram_arbiter_pkg::*;

  localparam int STARVE = 4;
  localparam logic [31:0] A_INST = 32'hBFC0_0000;
  localparam logic [31:0] A_DATA = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rq_req   [2];
  logic        rq_wr    [2];
  logic [1:0]  rq_size  [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic        maok, mdok;
  logic [31:0] mrdata;

  logic        i_aok, i_dok, d_aok, d_dok, mreq, mwr;
  logic [31:0] i_rdata, d_rdata, maddr, mwdata;
  logic [1:0]  msize;
  logic        zi_aok, zi_dok, zd_aok, zd_dok, zreq, zwr;
  logic [31:0] zi_rdata, zd_rdata, zaddr, zwdata;
  logic [1:0]  zsize;

  int n_chk = 0;
  int n_err = 0;

  // reference model: owner of the memory slot (-1 none, 0 inst, 1 data)
  int   m_owner = -1;
  bit   m_acc = 1'b0;
  int   m_starve = 0;
  bit   ev_aok [2];
  bit   ev_dok [2];
  bit   pend [2];
  bit   outst [2];
  bit   log_en = 1'b0;
  logic prev_mreq = 1'b0;
  logic prev_zreq = 1'b0;
  logic [31:0] dut_log [$];
  logic [31:0] z_log [$];

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(rq_req[0]), .inst_wr(rq_wr[0]), .inst_size(rq_size[0]),
    .inst_addr(rq_addr[0]), .inst_wdata(rq_wdata[0]),
    .inst_addr_ok(i_aok), .inst_data_ok(i_dok), .inst_rdata(i_rdata),
    .data_req(rq_req[1]), .data_wr(rq_wr[1]), .data_size(rq_size[1]),
    .data_addr(rq_addr[1]), .data_wdata(rq_wdata[1]),
    .data_addr_ok(d_aok), .data_data_ok(d_dok), .data_rdata(d_rdata),
    .mem_req(mreq), .mem_wr(mwr), .mem_size(msize), .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_addr_ok(maok), .mem_data_ok(mdok), .mem_rdata(mrdata)
  );

  cpu_sram_arbiter #(.STARVE_MAX(0)) dut_strict (
    .clk(clk), .resetn(resetn),
    .inst_req(rq_req[0]), .inst_wr(rq_wr[0]), .inst_size(rq_size[0]),
    .inst_addr(rq_addr[0]), .inst_wdata(rq_wdata[0]),
    .inst_addr_ok(zi_aok), .inst_data_ok(zi_dok), .inst_rdata(zi_rdata),
    .data_req(rq_req[1]), .data_wr(rq_wr[1]), .data_size(rq_size[1]),
    .data_addr(rq_addr[1]), .data_wdata(rq_wdata[1]),
    .data_addr_ok(zd_aok), .data_data_ok(zd_dok), .data_rdata(zd_rdata),
    .mem_req(zreq), .mem_wr(zwr), .mem_size(zsize), .mem_addr(zaddr), .mem_wdata(zwdata),
    .mem_addr_ok(maok), .mem_data_ok(mdok), .mem_rdata(mrdata)
  );

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick_model(input bit ir, input bit dr);
    if (!ir) return 1;
    if (!dr) return 0;
    return (m_starve >= STARVE) ? 0 : 1;
  endfunction

  task automatic sample();
    bit exp_req, dok_now;
    int o, w;
    @(negedge clk);
    if (!resetn) begin
      m_owner = -1; m_acc = 1'b0; m_starve = 0;
    end
    o = (m_owner < 0) ? 0 : m_owner;
    exp_req = (m_owner >= 0) && !m_acc;
    dok_now = (m_owner >= 0) && m_acc && mdok;
    ev_aok[0] = exp_req && maok && (m_owner == 0);
    ev_aok[1] = exp_req && maok && (m_owner == 1);
    ev_dok[0] = dok_now && (m_owner == 0);
    ev_dok[1] = dok_now && (m_owner == 1);
    check_val("mem_fields", {mreq, mwr, msize, maddr, mwdata},
              exp_req ? {1'b1, rq_wr[o], rq_size[o], rq_addr[o], rq_wdata[o]} : 68'd0);
    check_val("addr_ok", {i_aok, d_aok}, {ev_aok[0], ev_aok[1]});
    check_val("data_ok", {i_dok, d_dok}, {ev_dok[0], ev_dok[1]});
    check_val("rdata", {i_rdata, d_rdata}, {mrdata, mrdata});
    if (log_en && mreq && !prev_mreq) dut_log.push_back(maddr);
    if (log_en && zreq && !prev_zreq) z_log.push_back(zaddr);
    prev_mreq = mreq;
    prev_zreq = zreq;
    if (resetn) begin
      if ((m_owner < 0 || dok_now) && (rq_req[0] || rq_req[1])) begin
        w = pick_model(rq_req[0], rq_req[1]);
        if (w == 0) m_starve = 0;
        else if (rq_req[0]) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
        m_owner = w;
        m_acc = 1'b0;
      end else if (dok_now) begin
        m_owner = -1;
      end else if (exp_req && maok) begin
        m_acc = 1'b1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_rq(input int r, input bit req, input bit wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    rq_req[r] = req; rq_wr[r] = wr; rq_size[r] = sz; rq_addr[r] = addr; rq_wdata[r] = wd;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_rq(0, 1'b0, 1'b0, SZ_WORD, 32'd0, 32'd0);
    set_rq(1, 1'b0, 1'b0, SZ_WORD, 32'd0, 32'd0);
    maok = 1'b0; mdok = 1'b0; mrdata = 32'd0;
    cyc();
    check_val("reset_outs", {mreq, mwr, msize, maddr, mwdata, i_aok, d_aok, i_dok, d_dok}, '0);
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    int n_inst;
    do_reset();

    // single inst read: addr_ok in cycle 1, data_ok in cycle 3
    set_rq(0, 1'b1, 1'b0, SZ_WORD, A_INST, 32'd0);
    maok = 1'b1;
    cyc();
    sample();
    check_val("t1_addr_ok", {i_aok, d_aok, mreq, maddr}, {1'b1, 1'b0, 1'b1, A_INST});
    advance();
    rq_req[0] = 1'b0; maok = 1'b0;
    cyc();
    mdok = 1'b1; mrdata = 32'h2401_0001;
    sample();
    check_val("t1_data_ok", {i_dok, d_dok, d_aok, i_rdata}, {1'b1, 1'b0, 1'b0, 32'h2401_0001});
    advance();
    mdok = 1'b0;
    cyc();

    // simultaneous requests: data first, inst right after data's data_ok
    do_reset();
    set_rq(0, 1'b1, 1'b0, SZ_WORD, A_INST + 32'd4, 32'd0);
    set_rq(1, 1'b1, 1'b1, SZ_WORD, A_DATA, 32'hDEAD_BEEF);
    maok = 1'b1;
    cyc();
    sample();
    check_val("t2_data_first", {mreq, mwr, msize, maddr, mwdata, d_aok, i_aok},
              {1'b1, 1'b1, 2'b10, A_DATA, 32'hDEAD_BEEF, 1'b1, 1'b0});
    advance();
    rq_req[1] = 1'b0; mdok = 1'b1;
    sample();
    check_val("t2_data_ok", {d_dok, i_dok}, 2'b10);
    advance();
    mdok = 1'b0;
    sample();
    check_val("t2_inst_next", {mreq, maddr, i_aok}, {1'b1, A_INST + 32'd4, 1'b1});
    advance();
    rq_req[0] = 1'b0; mdok = 1'b1;
    cyc();
    mdok = 1'b0; maok = 1'b0;
    cyc();

    // continuous contention: starvation override vs strict priority
    do_reset();
    set_rq(0, 1'b1, 1'b0, SZ_WORD, A_INST, 32'd0);
    set_rq(1, 1'b1, 1'b0, SZ_WORD, A_DATA, 32'd0);
    maok = 1'b1; mdok = 1'b1;
    dut_log.delete(); z_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    log_en = 1'b0;
    check_val("t3_count", dut_log.size(), 10);
    for (int i = 0; i < 10 && i < dut_log.size(); i++)
      check_val($sformatf("t3_grant%0d", i), dut_log[i], (i % 5 == 4) ? A_INST : A_DATA);
    n_inst = 0;
    foreach (z_log[i]) if (z_log[i] == A_INST) n_inst++;
    check_val("t3_strict_count", z_log.size(), 10);
    check_val("t3_strict_inst", n_inst, 0);

    // memory stalls addr_ok for 5 cycles
    do_reset();
    set_rq(0, 1'b1, 1'b0, SZ_HALF, A_INST + 32'h10, 32'h55AA_0000);
    cyc();
    for (int i = 0; i < 5; i++) begin
      sample();
      check_val($sformatf("t4_stall%0d", i), {mreq, mwr, msize, maddr, mwdata, i_aok},
                {1'b1, 1'b0, SZ_HALF, A_INST + 32'h10, 32'h55AA_0000, 1'b0});
      advance();
    end
    maok = 1'b1;
    sample();
    check_val("t4_accept", {mreq, i_aok}, 2'b11);
    advance();
    rq_req[0] = 1'b0; maok = 1'b0; mdok = 1'b1;
    cyc();
    mdok = 1'b0;
    cyc();

    // reset while WAIT: outputs drop at once, stale data_ok ignored afterwards
    do_reset();
    set_rq(1, 1'b1, 1'b0, SZ_BYTE, 32'h0000_3003, 32'd0);
    maok = 1'b1;
    cyc();
    cyc();
    rq_req[1] = 1'b0; maok = 1'b0;
    cyc();
    mdok = 1'b1;
    resetn = 1'b0;
    #1;
    check_val("t5_async", {mreq, mwr, msize, maddr, mwdata, i_aok, d_aok, i_dok, d_dok}, '0);
    cyc();
    cyc();
    resetn = 1'b1;
    sample();
    check_val("t5_stale", {i_dok, d_dok, mreq}, 3'b000);
    advance();
    mdok = 1'b0;
    set_rq(1, 1'b1, 1'b0, SZ_WORD, 32'h0000_4000, 32'd0);
    cyc();
    maok = 1'b1;
    sample();
    check_val("t5_resume", {mreq, maddr, d_aok}, {1'b1, 32'h0000_4000, 1'b1});
    advance();
    rq_req[1] = 1'b0; maok = 1'b0; mdok = 1'b1;
    cyc();
    mdok = 1'b0;

    // spurious data_ok in IDLE
    do_reset();
    mdok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_val($sformatf("t6_spurious%0d", i), {i_dok, d_dok, mreq}, 3'b000);
      advance();
    end
    mdok = 1'b0;
    set_rq(0, 1'b1, 1'b0, SZ_WORD, A_INST + 32'h20, 32'd0);
    cyc();
    maok = 1'b1;
    sample();
    check_val("t6_idle_kept", {mreq, i_aok}, 2'b11);
    advance();
    rq_req[0] = 1'b0; maok = 1'b0; mdok = 1'b1;
    cyc();
    mdok = 1'b0;

    // random traffic with random (possibly spurious) memory handshakes
    do_reset();
    for (int r = 0; r < 2; r++) begin pend[r] = 1'b0; outst[r] = 1'b0; end
    for (int i = 0; i < 3000; i++) begin
      resetn = !(i >= 1500 && i < 1502);
      for (int r = 0; r < 2; r++) begin
        if (!resetn) begin
          pend[r] = 1'b0; outst[r] = 1'b0;
        end else begin
          if (pend[r] && ev_aok[r]) begin pend[r] = 1'b0; outst[r] = 1'b1; end
          if (outst[r] && ev_dok[r]) outst[r] = 1'b0;
          if (!pend[r] && !outst[r] && $urandom_range(0, 2) == 0) begin
            set_rq(r, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
            pend[r] = 1'b1;
          end
        end
        rq_req[r] = pend[r];
      end
      maok = 1'($urandom_range(0, 1));
      mdok = ($urandom_range(0, 2) != 0);
      mrdata = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
